uart_tx_word: RTL

- UART transmitter on the CPU side: the return path to the host, opposite to the instruction-loading UART receiver.
- Accepts 16-bit words (ALU results, memory dump words) from CPU control, buffers them in a small FIFO, and serialises each word as two 8N1 frames on o_tx, high byte first.
- Line format matches the instruction loader: 115200 baud at 100 MHz, LSB first, idle high.

---
 rtl/uart_tx_word.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_word.sv
// 16-bit word UART transmitter: FIFO-buffered, high byte first, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_word #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [15:0]                   i_word,
  input  logic                          i_word_valid,
  output logic                          o_word_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_overflow
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  localparam logic HI = 1'b0;
  localparam logic LO = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } state_t;
`endif

  state_t          state;
  logic [DW-1:0]   div_cnt;
  logic            div_last;
  logic [2:0]      bit_idx;
  logic [7:0]      shifter;
  logic [15:0]     hold;
  logic            byte_sel;

  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [15:0]     fifo_rd;
  logic            fifo_ne;
  logic            push;
  logic            pop;

  assign div_last = (div_cnt == DW'(DIV - 1));
  assign fifo_ne  = (count != '0);
  assign fifo_rd  = mem[rptr];

  // Ready comes from the registered count, so a same-cycle pop never frees a slot.
  assign o_word_ready = (count < CW'(FIFO_DEPTH));
  assign push         = i_word_valid & o_word_ready;

  assign pop = fifo_ne &
               ((state == S_IDLE) |
                ((state == S_STOP) & div_last & (byte_sel == LO)));

  assign o_fifo_count = count;
  assign o_busy       = (state != S_IDLE) | fifo_ne;

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wptr] <= i_word;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (i_word_valid & ~o_word_ready)
        o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      o_tx     <= 1'b1;
      div_cnt  <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      hold     <= '0;
      byte_sel <= HI;
    end else begin
      div_cnt <= div_last ? '0 : div_cnt + DW'(1);
      unique case (state)
        S_IDLE: begin
          div_cnt <= '0;
          o_tx    <= 1'b1;
          if (pop) begin
            hold     <= fifo_rd;
            shifter  <= fifo_rd[15:8];
            byte_sel <= HI;
            o_tx     <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (div_last) begin
            bit_idx <= '0;
            o_tx    <= shifter[0];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (div_last) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              o_tx  <= ^shifter;
              state <= S_PARITY;
`else
              o_tx  <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              o_tx    <= shifter[bit_idx + 3'd1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (div_last) begin
            o_tx  <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (div_last) begin
            if (byte_sel == HI) begin
              shifter  <= hold[7:0];
              byte_sel <= LO;
              o_tx     <= 1'b0;
              state    <= S_START;
            end else if (pop) begin
              hold     <= fifo_rd;
              shifter  <= fifo_rd[15:8];
              byte_sel <= HI;
              o_tx     <= 1'b0;
              state    <= S_START;
            end else begin
              o_tx  <= 1'b1;
              state <= S_IDLE;
            end
          end
        end
        default: begin
          o_tx  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
